pong_match_ctrl: RTL and testbench
==================================

Name: pong_match_ctrl

Overview:
- Two-player match sequencer for the pong game. Replaces the single-player score/ball FSM.
- Tracks per-player scores and decides serve direction and win. Freezes or releases the graphics engine and pulses ball re-centre.
- Sits between pong_graph (hit/miss sources) and pong_text (score display). Counts 60 Hz frame ticks for its delays.

Parameters:
- WIN_SCORE, 7, points needed to win (1..15).
- SERVE_DELAY_FRAMES, 120, frame ticks the ball is held before auto-launch.
- OVER_FRAMES, 180, frame ticks the game-over screen is held.
- TMR_W, 8, frame-timer width; must hold max(SERVE_DELAY_FRAMES, OVER_FRAMES).

Ports:
- top_clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- frame_tick  in  1  one-cycle pulse per frame (x==0 && y==0)
- start_req  in  1  level, any player button held
- pause_req  in  1  level, pause button held
- hit_l  in  1  ball struck left paddle (1-cycle pulse)
- hit_r  in  1  ball struck right paddle (1-cycle pulse)
- miss_l  in  1  ball passed left edge (1-cycle pulse)
- miss_r  in  1  ball passed right edge (1-cycle pulse)
- gra_still  out  1  1 = freeze ball/paddle animation
- ball_reset  out  1  1-cycle pulse: re-centre ball
- serve_dir  out  1  0 = serve toward left player, 1 = toward right
- score_l  out  4  left score, binary
- score_r  out  4  right score, binary
- winner  out  2  00 none, 01 left, 10 right
- rally_cnt  out  8  paddle hits since last serve, saturating
- state_out  out  3  current state encoding

Behaviour:
- All outputs registered. Reset values:
  - gra_still=1, ball_reset=0, serve_dir=1.
  - score_l=score_r=0, winner=00, rally_cnt=0, state=IDLE.
- Reset asserted mid-operation returns everything to these values immediately.
- start_req and pause_req are edge-detected internally with a registered previous value. An "edge" is a 0->1 transition. The previous-value registers reset to 1, so a button held through reset does not fire.
- States: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4. Codes 5-7 go to IDLE next cycle.
- Frame timer: loaded with the delay on state entry, decremented on frame_tick. "Expired" means the count is 0 and frame_tick is high.
- IDLE:
  - gra_still=1; previous scores and winner remain displayed.
  - On start edge: clear scores, winner and rally_cnt; set serve_dir=1; pulse ball_reset; load SERVE_DELAY_FRAMES; go to SERVE.
- SERVE:
  - gra_still=1.
  - On timer expiry: go to PLAY, with gra_still=0 from the next cycle.
  - hit/miss inputs are ignored.
- PLAY:
  - gra_still=0.
  - hit_l or hit_r: rally_cnt+1, saturating at 255.
  - miss_l alone: score_r+1, serve_dir=0 (serve toward the player who conceded).
  - miss_r alone: score_l+1, serve_dir=1.
  - miss_l and miss_r together: no score change; replay with serve_dir unchanged.
  - A miss in the same cycle as a hit: the miss wins and the hit is discarded.
  - After any miss: if the new score equals WIN_SCORE, set winner, load OVER_FRAMES and go to OVER. Otherwise pulse ball_reset, clear rally_cnt, load SERVE_DELAY_FRAMES and go to SERVE.
  - Latency: a miss pulse in cycle n gives updated score, state and ball_reset in cycle n+1.
  - A pause edge with no miss that cycle goes to PAUSE. If a miss is also present, the miss has priority and the pause is dropped.
- PAUSE:
  - gra_still=1; hit/miss are ignored.
  - A pause edge returns to PLAY. The timer is untouched.
- OVER:
  - gra_still=1; scores and winner are held.
  - On timer expiry: go to IDLE. Start edges are ignored.
- Scores never exceed WIN_SCORE, or 15 under DEUCE_EN.

Optional Feature:
- Macro: PONG_MATCH_DEUCE_EN.
- Defined: win-by-two rule.
  - After a point, a player wins only if their score >= WIN_SCORE and their lead >= 2.
  - If a score would reach 15 without a 2-point lead, that player wins at 15.
  - A new output deuce (1 bit) is 1 while both scores >= WIN_SCORE-1 and equal, else 0. It resets to 0.
- Undefined: first to WIN_SCORE wins; no deuce port.

Test Plan:
All scenarios use WIN_SCORE=3, SERVE_DELAY_FRAMES=2, OVER_FRAMES=4.
1. Reset, then a start_req rising edge -> next cycle: state=SERVE, ball_reset=1 for one cycle, scores 0/0, serve_dir=1. After 3 frame_ticks -> state=PLAY, gra_still=0.
2. In PLAY: 3 hit_r pulses, then miss_l -> rally_cnt 3 then 0, score_r=1, serve_dir=0, state=SERVE.
3. miss_r pulsed three times, each from PLAY -> score_l=3, winner=01, state=OVER. After 5 frame_ticks -> IDLE with score_l=3 retained. Start edge -> scores 0/0.
4. miss_l and miss_r in the same cycle, scores 1/1, serve_dir=0 -> scores stay 1/1, serve_dir=0, ball_reset pulse, state=SERVE.
5. PLAY, pause_req edge -> PAUSE, gra_still=1. A miss_r pulse there -> score unchanged. Second pause edge -> PLAY.
6. DEUCE_EN, scores 2/2, then miss_l, miss_r, miss_r -> 2/3 no win, then 3/3 with deuce=1, then 4/3 with no win yet. One more miss_r -> 5/3, winner=01.

Source files
------------

// File: rtl/pong_match_ctrl.sv
// ---------------------------------------------------------------------------
// pong_match_ctrl
// Two-player match sequencer for pong. It tracks both scores, picks the serve
// direction, decides the winner, freezes or releases the graphics engine and
// pulses a ball re-centre. Its delays are counted in 60 Hz frame ticks.
//
// Optional feature macro: PONG_MATCH_DEUCE_EN
//   When defined, the win-by-two rule applies and a 'deuce' output is added.
//   When undefined, the first player to WIN_SCORE wins.
//
// Ports
//   top_clk     in   system clock
//   reset       in   asynchronous active-high reset
//   frame_tick  in   one-cycle pulse per frame
//   start_req   in   level, any player button held (edge-detected here)
//   pause_req   in   level, pause button held (edge-detected here)
//   hit_l/hit_r in   ball struck left/right paddle (pulse)
//   miss_l/r    in   ball passed left/right edge (pulse)
//   gra_still   out  1 = freeze ball/paddle animation
//   ball_reset  out  one-cycle pulse, re-centre ball
//   serve_dir   out  0 = serve toward left player, 1 = toward right
//   score_l/r   out  4-bit binary scores
//   winner      out  00 none, 01 left, 10 right
//   rally_cnt   out  paddle hits since last serve, saturating
//   state_out   out  current state encoding
//   deuce       out  (PONG_MATCH_DEUCE_EN only) tied scores at game point
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module pong_match_ctrl #(
   parameter int unsigned WIN_SCORE          = 7,
   parameter int unsigned SERVE_DELAY_FRAMES = 120,
   parameter int unsigned OVER_FRAMES        = 180,
   parameter int unsigned TMR_W              = 8
) (
   input  logic       top_clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start_req,
   input  logic       pause_req,
   input  logic       hit_l,
   input  logic       hit_r,
   input  logic       miss_l,
   input  logic       miss_r,
   output logic       gra_still,
   output logic       ball_reset,
   output logic       serve_dir,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic [1:0] winner,
   output logic [7:0] rally_cnt,
`ifdef PONG_MATCH_DEUCE_EN
   output logic       deuce,
`endif
   output logic [2:0] state_out
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_PAUSE = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   localparam logic [3:0]       WIN_S    = 4'(WIN_SCORE);
   localparam logic [TMR_W-1:0] SERVE_LD = TMR_W'(SERVE_DELAY_FRAMES);
   localparam logic [TMR_W-1:0] OVER_LD  = TMR_W'(OVER_FRAMES);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

   state_t           state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [3:0]       score_l_q, score_l_d;
   logic [3:0]       score_r_q, score_r_d;
   logic [1:0]       winner_q, winner_d;
   logic [7:0]       rally_q, rally_d;
   logic             serve_dir_q, serve_dir_d;
   logic             ball_reset_q, ball_reset_d;
   logic             gra_still_q, gra_still_d;
   logic             start_prev_q, pause_prev_q;
   logic             start_edge, pause_edge, expired;
   logic [3:0]       new_l, new_r;
   logic             l_wins, r_wins;

   assign start_edge = start_req & ~start_prev_q;
   assign pause_edge = pause_req & ~pause_prev_q;
   assign expired    = (timer_q == '0) & frame_tick;
   assign new_l      = score_l_q + 4'd1;
   assign new_r      = score_r_q + 4'd1;

`ifdef PONG_MATCH_DEUCE_EN
   localparam logic [3:0] WIN_M1 = WIN_S - 4'd1;
   logic deuce_q, deuce_d;

   // Win-by-two, with a hard cap at 15 so the 4-bit score cannot wrap.
   assign l_wins = (new_l == 4'd15) ||
                   ((new_l >= WIN_S) && ({1'b0, new_l} >= ({1'b0, score_r_q} + 5'd2)));
   assign r_wins = (new_r == 4'd15) ||
                   ((new_r >= WIN_S) && ({1'b0, new_r} >= ({1'b0, score_l_q} + 5'd2)));
   assign deuce_d = (score_l_d >= WIN_M1) && (score_r_d >= WIN_M1) && (score_l_d == score_r_d);
   assign deuce   = deuce_q;
`else
   assign l_wins = (new_l == WIN_S);
   assign r_wins = (new_r == WIN_S);
`endif

   // Next-state and next-output logic for the match sequencer.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      score_l_d    = score_l_q;
      score_r_d    = score_r_q;
      winner_d     = winner_q;
      rally_d      = rally_q;
      serve_dir_d  = serve_dir_q;
      ball_reset_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_edge) begin
               score_l_d    = 4'd0;
               score_r_d    = 4'd0;
               winner_d     = 2'b00;
               rally_d      = 8'd0;
               serve_dir_d  = 1'b1;
               ball_reset_d = 1'b1;
               timer_d      = SERVE_LD;
               state_d      = ST_SERVE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SERVE: begin
            if (expired) begin
               state_d = ST_PLAY;
            end else if (frame_tick) begin
               timer_d = timer_q - TMR_ONE;
            end else begin
               timer_d = timer_q;
            end
         end
         ST_PLAY: begin
            if (miss_l || miss_r) begin
               // A miss always beats a hit or a pause in the same cycle.
               if (miss_l && miss_r) begin
                  // Simultaneous misses replay the point unchanged.
                  score_l_d = score_l_q;
               end else if (miss_l) begin
                  score_r_d   = new_r;
                  serve_dir_d = 1'b0;
               end else begin
                  score_l_d   = new_l;
                  serve_dir_d = 1'b1;
               end
               if ((miss_r && !miss_l && l_wins) || (miss_l && !miss_r && r_wins)) begin
                  winner_d = (miss_r) ? 2'b01 : 2'b10;
                  timer_d  = OVER_LD;
                  state_d  = ST_OVER;
               end else begin
                  ball_reset_d = 1'b1;
                  rally_d      = 8'd0;
                  timer_d      = SERVE_LD;
                  state_d      = ST_SERVE;
               end
            end else begin
               if ((hit_l || hit_r) && (rally_q != 8'hFF)) begin
                  rally_d = rally_q + 8'd1;
               end else begin
                  rally_d = rally_q;
               end
               if (pause_edge) begin
                  state_d = ST_PAUSE;
               end else begin
                  state_d = ST_PLAY;
               end
            end
         end
         ST_PAUSE: begin
            if (pause_edge) begin
               state_d = ST_PLAY;
            end else begin
               state_d = ST_PAUSE;
            end
         end
         ST_OVER: begin
            if (expired) begin
               state_d = ST_IDLE;
            end else if (frame_tick) begin
               timer_d = timer_q - TMR_ONE;
            end else begin
               timer_d = timer_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Registered from next state so the freeze lines up with state_out.
      gra_still_d = (state_d != ST_PLAY);
   end

   // Match state, scores, timer and output registers.
   always_ff @(posedge top_clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         score_l_q    <= 4'd0;
         score_r_q    <= 4'd0;
         winner_q     <= 2'b00;
         rally_q      <= 8'd0;
         serve_dir_q  <= 1'b1;
         ball_reset_q <= 1'b0;
         gra_still_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         score_l_q    <= score_l_d;
         score_r_q    <= score_r_d;
         winner_q     <= winner_d;
         rally_q      <= rally_d;
         serve_dir_q  <= serve_dir_d;
         ball_reset_q <= ball_reset_d;
         gra_still_q  <= gra_still_d;
      end
   end

   // Button history for edge detection; resets high so a held button is ignored.
   always_ff @(posedge top_clk or posedge reset) begin
      if (reset) begin
         start_prev_q <= 1'b1;
         pause_prev_q <= 1'b1;
      end else begin
         start_prev_q <= start_req;
         pause_prev_q <= pause_req;
      end
   end

`ifdef PONG_MATCH_DEUCE_EN
   // Deuce indicator register.
   always_ff @(posedge top_clk or posedge reset) begin
      if (reset) begin
         deuce_q <= 1'b0;
      end else begin
         deuce_q <= deuce_d;
      end
   end
`endif

   assign gra_still  = gra_still_q;
   assign ball_reset = ball_reset_q;
   assign serve_dir  = serve_dir_q;
   assign score_l    = score_l_q;
   assign score_r    = score_r_q;
   assign winner     = winner_q;
   assign rally_cnt  = rally_q;
   assign state_out  = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pong_match_ctrl
// Directed scoreboard bench for pong_match_ctrl with WIN_SCORE=3,
// SERVE_DELAY_FRAMES=2, OVER_FRAMES=4. The stimulus pushes every expected
// output change into a queue; the monitor pops one entry whenever the sampled
// output vector changes and compares it.
// ---------------------------------------------------------------------------
module tb_pong_match_ctrl;

   typedef struct packed {
      logic [2:0] st;
      logic       gs;
      logic       br;
      logic       sd;
      logic [3:0] sl;
      logic [3:0] sr;
      logic [1:0] win;
      logic [7:0] rally;
      logic       dc;
   } obs_t;

   logic       top_clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       start_req = 1'b0;
   logic       pause_req = 1'b0;
   logic       hit_l = 1'b0;
   logic       hit_r = 1'b0;
   logic       miss_l = 1'b0;
   logic       miss_r = 1'b0;
   logic       gra_still, ball_reset, serve_dir;
   logic [3:0] score_l, score_r;
   logic [1:0] winner;
   logic [7:0] rally_cnt;
   logic [2:0] state_out;
`ifdef PONG_MATCH_DEUCE_EN
   logic       deuce;
`endif

   int   checks = 0;
   int   fails = 0;
   obs_t exp_q[$];
   obs_t e;
   obs_t rst_vals;
   obs_t prev_obs;

   pong_match_ctrl #(
      .WIN_SCORE(3), .SERVE_DELAY_FRAMES(2), .OVER_FRAMES(4), .TMR_W(8)
   ) dut (
      .top_clk(top_clk), .reset(reset), .frame_tick(frame_tick),
      .start_req(start_req), .pause_req(pause_req),
      .hit_l(hit_l), .hit_r(hit_r), .miss_l(miss_l), .miss_r(miss_r),
      .gra_still(gra_still), .ball_reset(ball_reset), .serve_dir(serve_dir),
      .score_l(score_l), .score_r(score_r), .winner(winner),
      .rally_cnt(rally_cnt),
`ifdef PONG_MATCH_DEUCE_EN
      .deuce(deuce),
`endif
      .state_out(state_out)
   );

   always #5 top_clk = ~top_clk;

   function automatic obs_t sample();
      obs_t s;
      s.st    = state_out;
      s.gs    = gra_still;
      s.br    = ball_reset;
      s.sd    = serve_dir;
      s.sl    = score_l;
      s.sr    = score_r;
      s.win   = winner;
      s.rally = rally_cnt;
`ifdef PONG_MATCH_DEUCE_EN
      s.dc    = deuce;
`else
      s.dc    = 1'b0;
`endif
      return s;
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("st=%0d gs=%0b br=%0b sd=%0b sl=%0d sr=%0d win=%0d rally=%0d dc=%0b",
                       o.st, o.gs, o.br, o.sd, o.sl, o.sr, o.win, o.rally, o.dc);
   endfunction

   task automatic chk(input string name, input obs_t got, input obs_t want);
      checks++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %s, required %s", name, fmt(got), fmt(want));
      end
   endtask

   // Monitor: every change of the output vector consumes one expected entry.
   always @(negedge top_clk) begin : monitor
      obs_t cur;
      obs_t want;
      cur = sample();
      if (reset) begin
         prev_obs = cur;
      end else if (cur !== prev_obs) begin
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_change: got %s, required %s", fmt(cur), fmt(prev_obs));
         end else begin
            want = exp_q.pop_front();
            chk("scoreboard", cur, want);
         end
         prev_obs = cur;
      end
   end

   task automatic step();
      @(posedge top_clk);
      #1;
   endtask

   task automatic push();
      exp_q.push_back(e);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
         step();
      end
   endtask

   // Expected entries for a return to SERVE: pulse up, then pulse down.
   task automatic serve_push();
      e.st = 3'd1; e.gs = 1'b1; e.br = 1'b1; e.rally = 8'd0;
      push();
      e.br = 1'b0;
      push();
   endtask

   // SERVE -> PLAY after the timer counts 2,1,0 and expires on the third tick.
   task automatic to_play();
      e.st = 3'd2; e.gs = 1'b0;
      push();
      frames(3);
   endtask

   task automatic miss(input logic l, input logic r);
      miss_l = l;
      miss_r = r;
      step();
      miss_l = 1'b0;
      miss_r = 1'b0;
      step();
   endtask

   task automatic hit(input logic l, input logic r);
      hit_l = l;
      hit_r = r;
      step();
      hit_l = 1'b0;
      hit_r = 1'b0;
      step();
   endtask

   initial begin
      rst_vals = '{st: 3'd0, gs: 1'b1, br: 1'b0, sd: 1'b1, sl: 4'd0, sr: 4'd0,
                   win: 2'b00, rally: 8'd0, dc: 1'b0};
      e = rst_vals;
      repeat (3) step();
      chk("reset_values", sample(), rst_vals);
      reset = 1'b0;
      repeat (2) step();

      // 1: start edge -> SERVE with a ball_reset pulse, then PLAY after 3 ticks.
      serve_push();
      start_req = 1'b1;
      step();
      start_req = 1'b0;
      step();
      to_play();

      // 2: three hits, then a miss with a simultaneous hit (miss wins).
      for (int i = 0; i < 3; i++) begin
         e.rally = e.rally + 8'd1;
         push();
         hit(1'b0, 1'b1);
      end
      e.sr = 4'd1; e.sd = 1'b0;
      serve_push();
      hit_l = 1'b1;
      miss(1'b1, 1'b0);
      hit_l = 1'b0;
      to_play();

      // 3: left scores three times -> OVER, then IDLE keeps the score.
      e.sl = 4'd1; e.sd = 1'b1;
      serve_push(); miss(1'b0, 1'b1); to_play();
      e.sl = 4'd2;
      serve_push(); miss(1'b0, 1'b1); to_play();
      e.sl = 4'd3; e.win = 2'b01; e.st = 3'd4; e.gs = 1'b1;
      push();
      miss(1'b0, 1'b1);
      // Start edge during OVER is ignored.
      start_req = 1'b1; step(); start_req = 1'b0; step();
      e.st = 3'd0;
      push();
      frames(5);
      // New game clears scores and winner.
      e.sl = 4'd0; e.sr = 4'd0; e.win = 2'b00; e.sd = 1'b1;
      serve_push();
      start_req = 1'b1; step(); start_req = 1'b0; step();
      to_play();

      // 4: reach 1/1 with serve_dir=0, then a double miss replays the point.
      e.sl = 4'd1; e.sd = 1'b1;
      serve_push(); miss(1'b0, 1'b1); to_play();
      e.sr = 4'd1; e.sd = 1'b0;
      serve_push(); miss(1'b1, 1'b0); to_play();
      serve_push(); miss(1'b1, 1'b1); to_play();

      // 5: pause, miss ignored while paused, resume; pause+miss -> miss wins.
      e.st = 3'd3; e.gs = 1'b1;
      push();
      pause_req = 1'b1; step();
      miss(1'b0, 1'b1);
      pause_req = 1'b0; step();
      e.st = 3'd2; e.gs = 1'b0;
      push();
      pause_req = 1'b1; step();
      pause_req = 1'b0; step();
      e.sr = 4'd2; e.sd = 1'b0;
      serve_push();
      pause_req = 1'b1;
      miss(1'b1, 1'b0);
      pause_req = 1'b0;
      to_play();
      e.sl = 4'd2; e.sd = 1'b1;
`ifdef PONG_MATCH_DEUCE_EN
      e.dc = 1'b1;
`endif
      serve_push(); miss(1'b0, 1'b1); to_play();

`ifdef PONG_MATCH_DEUCE_EN
      // 6: win-by-two from 2/2.
      e.sr = 4'd3; e.sd = 1'b0; e.dc = 1'b0;
      serve_push(); miss(1'b1, 1'b0); to_play();
      e.sl = 4'd3; e.sd = 1'b1; e.dc = 1'b1;
      serve_push(); miss(1'b0, 1'b1); to_play();
      e.sl = 4'd4; e.dc = 1'b0;
      serve_push(); miss(1'b0, 1'b1); to_play();
      e.sl = 4'd5; e.win = 2'b01; e.st = 3'd4; e.gs = 1'b1;
      push();
      miss(1'b0, 1'b1);
`else
      // Right player reaches WIN_SCORE from 2/2.
      e.sr = 4'd3; e.sd = 1'b0; e.win = 2'b10; e.st = 3'd4; e.gs = 1'b1;
      push();
      miss(1'b1, 1'b0);
`endif
      step();

      // Mid-operation reset takes effect without a clock edge.
      start_req = 1'b1;
      reset = 1'b1;
      #2;
      chk("async_reset", sample(), rst_vals);
      repeat (2) step();
      reset = 1'b0;
      // Start held through reset must not fire.
      repeat (4) step();
      chk("held_start_no_fire", sample(), rst_vals);
      start_req = 1'b0;
      repeat (4) step();

      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
